// File: rtl/spi_pkg.sv
// SPI responder shared definitions.
// Register map, bit positions and FSM states.
package spi_pkg;

  localparam logic [3:0] SPI_S_CTRL   = 4'h0;
  localparam logic [3:0] SPI_S_TXDATA = 4'h4;
  localparam logic [3:0] SPI_S_RXDATA = 4'h8;
  localparam logic [3:0] SPI_S_STATUS = 4'hC;

  localparam int CTRL_EN   = 0;
  localparam int CTRL_CPOL = 1;
  localparam int CTRL_CPHA = 2;
  localparam int CTRL_IE   = 3;

  localparam int ST_BUSY = 0;
  localparam int ST_RXV  = 1;
  localparam int ST_TXE  = 2;
  localparam int ST_OVR  = 3;
  localparam int ST_UNR  = 4;

  typedef enum logic {
    S_IDLE,
    S_ACTIVE
  } spi_state_e;

endpackage

// File: rtl/spi_slave_sync.sv
// Input synchronizer with edge pulses.
// Level after SYNC_STAGES flops; one history flop for edges.
module spi_slave_sync #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RST_VAL     = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic async_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;

  // shift the async input through the chain, keep last level
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sync_q <= {SYNC_STAGES{RST_VAL}};
      hist_q <= RST_VAL;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level_o = sync_q[SYNC_STAGES-1];
  assign rise_o  = level_o & ~hist_q;
  assign fall_o  = ~level_o & hist_q;

endmodule

// File: rtl/spi_slave.sv
// SPI responder on the simple register bus.
// Oversampled SCLK/SS_N/MOSI, all CPOL/CPHA modes.
module spi_slave
  import spi_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FRAME_BITS  = 8
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [31:0] data_i,
  input  logic [31:0] addr_i,
  input  logic        we_i,
  output logic [31:0] data_o,
  input  logic        spi_sclk,
  input  logic        spi_ss_n,
  input  logic        spi_mosi,
  output logic        spi_miso,
  output logic        spi_miso_oe,
  output logic        irq_o
);

  localparam int CW = $clog2(FRAME_BITS);
  localparam logic [CW-1:0] LAST = CW'(FRAME_BITS - 1);

  logic sclk_lvl, sclk_rise, sclk_fall;
  logic ss_lvl, ss_rise, ss_fall;
  logic mosi_lvl, mosi_rise, mosi_fall;

  spi_slave_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .async_i (spi_sclk),
    .level_o (sclk_lvl),
    .rise_o  (sclk_rise),
    .fall_o  (sclk_fall)
  );

  spi_slave_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ss (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .async_i (spi_ss_n),
    .level_o (ss_lvl),
    .rise_o  (ss_rise),
    .fall_o  (ss_fall)
  );

  spi_slave_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .async_i (spi_mosi),
    .level_o (mosi_lvl),
    .rise_o  (mosi_rise),
    .fall_o  (mosi_fall)
  );

  logic unused_bits;
  assign unused_bits = ^{addr_i[31:4], data_i[31:FRAME_BITS],
                         sclk_lvl, mosi_rise, mosi_fall};

  spi_state_e state_q, state_d;

  logic en_q, en_d, cpol_q, cpol_d;
  logic cpha_q, cpha_d, ie_q, ie_d;
  logic txe_q, txe_d, rxv_q, rxv_d;
  logic ovr_q, ovr_d, unr_q, unr_d;
  logic [FRAME_BITS-1:0] txdata_q, txdata_d;
  logic [FRAME_BITS-1:0] rxdata_q, rxdata_d;
  logic [FRAME_BITS-1:0] stx_q, stx_d;
  logic [FRAME_BITS-1:0] srx_q, srx_d;
  logic [CW-1:0]         cnt_q, cnt_d;

  logic busy;
  logic wr_ctrl, wr_tx, wr_st;
  logic lead, trail, in_frame;
  logic sample_ev, shift_ev, load_ev, rx_done;
  logic [FRAME_BITS-1:0] rx_byte;

  assign wr_ctrl = we_i && (addr_i[3:0] == SPI_S_CTRL);
  assign wr_tx   = we_i && (addr_i[3:0] == SPI_S_TXDATA);
  assign wr_st   = we_i && (addr_i[3:0] == SPI_S_STATUS);

  assign lead      = cpol_q ? sclk_fall : sclk_rise;
  assign trail     = cpol_q ? sclk_rise : sclk_fall;
  assign in_frame  = busy & en_q & ~ss_rise;
  assign sample_ev = in_frame & (cpha_q ? trail : lead);
  assign shift_ev  = in_frame & (cpha_q ? lead : trail);
  assign rx_done   = sample_ev && (cnt_q == LAST);
  assign rx_byte   = {srx_q[FRAME_BITS-2:0], mosi_lvl};

  // CPHA=0 preloads at select and after each full frame; CPHA=1 at first edge
  assign load_ev = cpha_q
    ? (in_frame && lead && (cnt_q == '0))
    : ((!busy && en_q && ss_fall) ||
       (in_frame && trail && (cnt_q == '0)));

  // FSM state register
  always_ff @(posedge clk_i) begin
    if (!rst_ni) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // FSM next state: follow the synchronized chip select
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (en_q && ss_fall)    state_d = S_ACTIVE;
      S_ACTIVE: if (!en_q || ss_rise)   state_d = S_IDLE;
      default:                          state_d = S_IDLE;
    endcase
  end

  // FSM outputs: busy flag and MISO driven only inside a frame
  always_comb begin
    busy     = 1'b0;
    spi_miso = 1'b0;
    unique case (state_q)
      S_ACTIVE: begin
        busy     = 1'b1;
        spi_miso = rst_ni & stx_q[FRAME_BITS-1];
      end
      default: begin
        busy     = 1'b0;
        spi_miso = 1'b0;
      end
    endcase
  end

  // next register values; hardware set wins over W1C clear
  always_comb begin
    en_d     = en_q;
    cpol_d   = cpol_q;
    cpha_d   = cpha_q;
    ie_d     = ie_q;
    txdata_d = txdata_q;
    rxdata_d = rxdata_q;
    stx_d    = stx_q;
    srx_d    = srx_q;
    cnt_d    = cnt_q;
    txe_d    = txe_q;
    rxv_d    = rxv_q & ~(wr_st & data_i[ST_RXV]);
    ovr_d    = ovr_q & ~(wr_st & data_i[ST_OVR]);
    unr_d    = unr_q & ~(wr_st & data_i[ST_UNR]);
    if (wr_ctrl) begin
      en_d   = data_i[CTRL_EN];
      cpol_d = data_i[CTRL_CPOL];
      cpha_d = data_i[CTRL_CPHA];
      ie_d   = data_i[CTRL_IE];
    end
    if (load_ev) begin
      if (txe_q) begin
        stx_d = '1;
        unr_d = 1'b1;
      end else begin
        stx_d = txdata_q;
      end
      txe_d = 1'b1;
    end else if (shift_ev) begin
      stx_d = {stx_q[FRAME_BITS-2:0], 1'b0};
    end
    if (wr_tx) begin
      txdata_d = data_i[FRAME_BITS-1:0];
      txe_d    = 1'b0;
    end
    if (sample_ev) begin
      srx_d = rx_byte;
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end
    if (rx_done) begin
      rxdata_d = rx_byte;
      rxv_d    = 1'b1;
      if (rxv_q) ovr_d = 1'b1;
    end
    if (state_d == S_IDLE) cnt_d = '0;
  end

  // register and frame datapath state
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      en_q     <= 1'b0;
      cpol_q   <= 1'b0;
      cpha_q   <= 1'b0;
      ie_q     <= 1'b0;
      txdata_q <= '0;
      rxdata_q <= '0;
      stx_q    <= '0;
      srx_q    <= '0;
      cnt_q    <= '0;
      txe_q    <= 1'b1;
      rxv_q    <= 1'b0;
      ovr_q    <= 1'b0;
      unr_q    <= 1'b0;
    end else begin
      en_q     <= en_d;
      cpol_q   <= cpol_d;
      cpha_q   <= cpha_d;
      ie_q     <= ie_d;
      txdata_q <= txdata_d;
      rxdata_q <= rxdata_d;
      stx_q    <= stx_d;
      srx_q    <= srx_d;
      cnt_q    <= cnt_d;
      txe_q    <= txe_d;
      rxv_q    <= rxv_d;
      ovr_q    <= ovr_d;
      unr_q    <= unr_d;
    end
  end

  logic [31:0] rdata;

  // combinational read mux on the low address nibble
  always_comb begin
    rdata = '0;
    unique case (addr_i[3:0])
      SPI_S_CTRL:   rdata = {28'b0, ie_q, cpha_q, cpol_q, en_q};
      SPI_S_TXDATA: rdata = 32'(txdata_q);
      SPI_S_RXDATA: rdata = 32'(rxdata_q);
      SPI_S_STATUS: rdata = {27'b0, unr_q, ovr_q, txe_q, rxv_q, busy};
      default:      rdata = '0;
    endcase
  end

  assign data_o      = rst_ni ? rdata : '0;
  assign spi_miso_oe = rst_ni & en_q & ~ss_lvl;
  assign irq_o       = rst_ni & ie_q & rxv_q;

endmodule
